// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg
// Shared definitions for the two-requester ALU arbiter:
//   - default operand/result and function-code widths
//   - the five function codes the shared ALU supports
//   - FSM state encoding
//   - helper that classifies a function code as supported or not
package alu_arbiter_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int FUNC_W_DEF = 4;

  localparam logic [FUNC_W_DEF-1:0] FUNC_CODE_0010 = 4'b0010;
  localparam logic [FUNC_W_DEF-1:0] FUNC_CODE_0100 = 4'b0100;
  localparam logic [FUNC_W_DEF-1:0] FUNC_CODE_0110 = 4'b0110;
  localparam logic [FUNC_W_DEF-1:0] FUNC_CODE_1000 = 4'b1000;
  localparam logic [FUNC_W_DEF-1:0] FUNC_CODE_1010 = 4'b1010;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_RESP  = 2'b10
  } state_e;

  // Returns 1 when the ALU implements the given function code.
  function automatic logic func_supported(input logic [FUNC_W_DEF-1:0] f);
    logic sup;
    case (f)
      FUNC_CODE_0010, FUNC_CODE_0100, FUNC_CODE_0110,
      FUNC_CODE_1000, FUNC_CODE_1010: sup = 1'b1;
      default:                        sup = 1'b0;
    endcase
    return sup;
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// rr_arb2
// Two-way round-robin grant with a 1-bit preference pointer.
// Ports:
//   clk, rst_n   clock, async active-low reset (pointer -> 0)
//   req          request bits, bit i = requester i
//   update       pulse: the served transaction has completed
//   served_idx   index of the requester that was just served
//   grant        one-hot grant (combinational)
//   grant_idx    index of the granted requester (combinational)
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  input  logic       served_idx,
  output logic [1:0] grant,
  output logic       grant_idx
);

  logic ptr_r;

  // Pointer register: after a completed transaction prefer the other requester.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= 1'b0;
    end else if (update) begin
      ptr_r <= ~served_idx;
    end else begin
      ptr_r <= ptr_r;
    end
  end

  // Grant selection: pointer only matters on a tie.
  always_comb begin
    grant     = 2'b00;
    grant_idx = 1'b0;
    case (req)
      2'b11: begin
        grant_idx = ptr_r;
        grant     = ptr_r ? 2'b10 : 2'b01;
      end
      2'b01: begin
        grant_idx = 1'b0;
        grant     = 2'b01;
      end
      2'b10: begin
        grant_idx = 1'b1;
        grant     = 2'b10;
      end
      default: begin
        grant_idx = 1'b0;
        grant     = 2'b00;
      end
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter
// Shares one external combinational ALU between two requesters.
// IDLE accepts one request (round-robin on a tie), ISSUE drives the ALU for
// one cycle and captures its result, RESP presents the result to the granted
// requester until it is consumed.
// Ports:
//   req_valid/req_ready           per-requester request handshake
//   req{0,1}_a/_b/_func           per-requester operands and function code
//   rsp_valid/rsp_ready           per-requester response handshake
//   rsp_data/rsp_err              registered result; err = unsupported code
//   alu_op_a/alu_op_b/alu_func    drive to the shared ALU (zero outside ISSUE)
//   alu_out                       combinational ALU result
//   busy                          high whenever not IDLE
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int FUNC_W = FUNC_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [FUNC_W-1:0] req0_func,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [FUNC_W-1:0] req1_func,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic [DATA_W-1:0] alu_op_a,
  output logic [DATA_W-1:0] alu_op_b,
  output logic [FUNC_W-1:0] alu_func,
  input  logic [DATA_W-1:0] alu_out,
  output logic              busy
);

  state_e            state_r;
  state_e            state_next_s;
  logic [1:0]        grant_s;
  logic              gnt_idx_s;
  logic              gnt_idx_r;
  logic              accept_s;
  logic              rsp_hs_s;
  logic [DATA_W-1:0] alu_op_a_r;
  logic [DATA_W-1:0] alu_op_b_r;
  logic [FUNC_W-1:0] alu_func_r;
  logic [1:0]        rsp_valid_r;
  logic [DATA_W-1:0] rsp_data_r;
  logic              rsp_err_r;

  assign accept_s = (state_r == ST_IDLE) && (req_valid != 2'b00);
  assign rsp_hs_s = (state_r == ST_RESP) && rsp_ready[gnt_idx_r];

  rr_arb2 u_arb (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req_valid),
    .update     (rsp_hs_s),
    .served_idx (gnt_idx_r),
    .grant      (grant_s),
    .grant_idx  (gnt_idx_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (req_valid != 2'b00) state_next_s = ST_ISSUE;
        else                    state_next_s = ST_IDLE;
      end
      ST_ISSUE: state_next_s = ST_RESP;
      ST_RESP: begin
        if (rsp_ready[gnt_idx_r]) state_next_s = ST_IDLE;
        else                      state_next_s = ST_RESP;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Output decode: accept pulse only in IDLE, and never while reset is held.
  always_comb begin
    req_ready = 2'b00;
    busy      = 1'b1;
    case (state_r)
      ST_IDLE: begin
        busy = 1'b0;
        if (rst_n) req_ready = grant_s;
        else       req_ready = 2'b00;
      end
      ST_ISSUE, ST_RESP: begin
        busy      = 1'b1;
        req_ready = 2'b00;
      end
      default: begin
        busy      = 1'b1;
        req_ready = 2'b00;
      end
    endcase
  end

  // Datapath: the ALU drive registers double as the operand latch, since
  // ISSUE always immediately follows the accept edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_idx_r   <= 1'b0;
      alu_op_a_r  <= {DATA_W{1'b0}};
      alu_op_b_r  <= {DATA_W{1'b0}};
      alu_func_r  <= {FUNC_W{1'b0}};
      rsp_valid_r <= 2'b00;
      rsp_data_r  <= {DATA_W{1'b0}};
      rsp_err_r   <= 1'b0;
    end else if (accept_s) begin
      gnt_idx_r  <= gnt_idx_s;
      alu_op_a_r <= gnt_idx_s ? req1_a    : req0_a;
      alu_op_b_r <= gnt_idx_s ? req1_b    : req0_b;
      alu_func_r <= gnt_idx_s ? req1_func : req0_func;
    end else if (state_r == ST_ISSUE) begin
      alu_op_a_r  <= {DATA_W{1'b0}};
      alu_op_b_r  <= {DATA_W{1'b0}};
      alu_func_r  <= {FUNC_W{1'b0}};
      rsp_valid_r <= gnt_idx_r ? 2'b10 : 2'b01;
      if (func_supported(alu_func_r)) begin
        rsp_data_r <= alu_out;
        rsp_err_r  <= 1'b0;
      end else begin
        rsp_data_r <= {DATA_W{1'b0}};
        rsp_err_r  <= 1'b1;
      end
    end else if (rsp_hs_s) begin
      rsp_valid_r <= 2'b00;
      rsp_data_r  <= {DATA_W{1'b0}};
      rsp_err_r   <= 1'b0;
    end
  end

  assign alu_op_a  = alu_op_a_r;
  assign alu_op_b  = alu_op_b_r;
  assign alu_func  = alu_func_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_data  = rsp_data_r;
  assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
// Self-checking bench: a behavioural ALU, a transaction-level reference model
// compared every cycle, and directed scenarios with literal expectations.
// ALU codes: 0010 add, 0100 sub, 0110 and, 1000 or, 1010 xor.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_func, req1_func;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic [15:0] alu_op_a, alu_op_b, alu_out;
  logic [3:0]  alu_func;
  logic        busy;

  int errors = 0;
  int checks = 0;

  alu_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_func(req0_func),
    .req1_a(req1_a), .req1_b(req1_b), .req1_func(req1_func),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .alu_op_a(alu_op_a), .alu_op_b(alu_op_b),
    .alu_func(alu_func), .alu_out(alu_out), .busy(busy)
  );

  always #5 clk = ~clk;

  // The shared ALU; unsupported codes produce a non-zero marker value.
  always_comb begin
    case (alu_func)
      4'b0010: alu_out = alu_op_a + alu_op_b;
      4'b0100: alu_out = alu_op_a - alu_op_b;
      4'b0110: alu_out = alu_op_a & alu_op_b;
      4'b1000: alu_out = alu_op_a | alu_op_b;
      4'b1010: alu_out = alu_op_a ^ alu_op_b;
      default: alu_out = 16'hDEAD;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit supported(input logic [3:0] f);
    return f inside {4'b0010, 4'b0100, 4'b0110, 4'b1000, 4'b1010};
  endfunction

  // What the requester must receive: the ALU result, or 0 for an unsupported code.
  function automatic logic [15:0] ref_result(input logic [15:0] a, input logic [15:0] b,
                                             input logic [3:0] f);
    case (f)
      4'b0010: return a + b;
      4'b0100: return a - b;
      4'b0110: return a & b;
      4'b1000: return a | b;
      4'b1010: return a ^ b;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic bit pick(input logic [1:0] v, input bit p);
    if (v == 2'b11)  return p;
    else if (v[0])   return 1'b0;
    else             return 1'b1;
  endfunction

  // Reference model: one transaction in flight, timestamped by its accept cycle.
  int          cyc = 0;
  int          m_acc = 0;
  bit          m_active = 1'b0;
  bit          m_ptr = 1'b0;
  bit          m_g = 1'b0;
  logic [15:0] m_a = 16'h0, m_b = 16'h0;
  logic [3:0]  m_f = 4'h0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0;
      m_ptr    <= 1'b0;
      cyc      <= 0;
    end else begin
      cyc <= cyc + 1;
      if (!m_active) begin
        if (req_valid != 2'b00) begin
          m_active <= 1'b1;
          m_acc    <= cyc + 1;
          m_g      <= pick(req_valid, m_ptr);
          m_a      <= pick(req_valid, m_ptr) ? req1_a : req0_a;
          m_b      <= pick(req_valid, m_ptr) ? req1_b : req0_b;
          m_f      <= pick(req_valid, m_ptr) ? req1_func : req0_func;
        end
      end else if (cyc > m_acc && rsp_ready[m_g]) begin
        m_active <= 1'b0;
        m_ptr    <= ~m_g;
      end
    end
  end

  function automatic bit in_issue();
    return m_active && (cyc == m_acc);
  endfunction

  function automatic bit in_resp();
    return m_active && (cyc > m_acc);
  endfunction

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    chk("cmp_req_ready", 32'(req_ready),
        32'((!m_active && rst_n && req_valid != 2'b00) ? (2'b01 << pick(req_valid, m_ptr)) : 2'b00));
    chk("cmp_busy", 32'(busy), 32'(m_active));
    chk("cmp_alu_op_a", 32'(alu_op_a), 32'(in_issue() ? m_a : 16'h0000));
    chk("cmp_alu_op_b", 32'(alu_op_b), 32'(in_issue() ? m_b : 16'h0000));
    chk("cmp_alu_func", 32'(alu_func), 32'(in_issue() ? m_f : 4'h0));
    chk("cmp_rsp_valid", 32'(rsp_valid), 32'(in_resp() ? (m_g ? 2'b10 : 2'b01) : 2'b00));
    chk("cmp_rsp_data", 32'(rsp_data), 32'(in_resp() ? ref_result(m_a, m_b, m_f) : 16'h0000));
    chk("cmp_rsp_err", 32'(rsp_err), 32'(in_resp() && !supported(m_f)));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(input logic [1:0] which);
    bit got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (rsp_valid == which) got = 1'b1;
    end
    chk("rsp_wait_timeout", 32'(got), 32'd1);
  endtask

  task automatic wait_idle();
    bit got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (!busy) got = 1'b1;
    end
    chk("idle_wait_timeout", 32'(got), 32'd1);
  endtask

  task automatic do_txn(input bit idx, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] f, output logic [15:0] d, output logic e);
    bit got = 1'b0;
    d = 16'h0;
    e = 1'b0;
    tick();
    if (idx == 1'b0) begin
      req0_a = a; req0_b = b; req0_func = f;
    end else begin
      req1_a = a; req1_b = b; req1_func = f;
    end
    req_valid[idx] = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (req_ready[idx]) got = 1'b1;
      else tick();
    end
    chk("accept_timeout", 32'(got), 32'd1);
    tick();
    req_valid[idx] = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (rsp_valid[idx]) begin
        got = 1'b1;
        d   = rsp_data;
        e   = rsp_err;
      end
    end
    chk("rsp_timeout", 32'(got), 32'd1);
  endtask

  initial begin
    logic [15:0] d, d0, d1;
    logic        e;
    bit          order[4];
    int          ng;
    logic [3:0]  codes[5];
    logic [15:0] a_v, b_v;

    codes = '{4'b0010, 4'b0100, 4'b0110, 4'b1000, 4'b1010};
    req_valid = 2'b00; rsp_ready = 2'b11;
    req0_a = 16'h0; req0_b = 16'h0; req0_func = 4'h0;
    req1_a = 16'h0; req1_b = 16'h0; req1_func = 4'h0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;

    // Reset: outputs quiet even with requests pending.
    req_valid = 2'b11;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    req_valid = 2'b00;
    @(posedge clk);
    #3 rst_n = 1'b1;

    // Sustained tie after reset: grants 0,1,0,1; sub with b=FF84.
    tick();
    req0_a = 16'h0100; req0_b = 16'hFF84; req0_func = 4'b0100;
    req1_a = 16'h0004; req1_b = 16'hFF84; req1_func = 4'b0100;
    req_valid = 2'b11;
    ng = 0; d0 = 16'h0; d1 = 16'h0;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      @(negedge clk);
      if (req_ready != 2'b00) begin
        order[ng] = req_ready[1];
        ng++;
      end
      if (rsp_valid == 2'b01) d0 = rsp_data;
      if (rsp_valid == 2'b10) d1 = rsp_data;
      tick();
      if (ng == 4) req_valid = 2'b00;
    end
    req_valid = 2'b00;
    chk("tie_grant_count", 32'(ng), 32'd4);
    chk("tie_grant0", 32'(order[0]), 32'd0);
    chk("tie_grant1", 32'(order[1]), 32'd1);
    chk("tie_grant2", 32'(order[2]), 32'd0);
    chk("tie_grant3", 32'(order[3]), 32'd1);
    chk("tie_data0", 32'(d0), 32'h017C);
    chk("tie_data1", 32'(d1), 32'h0080);
    wait_idle();

    // Single request, exact latency.
    tick();
    req0_a = 16'h0001; req0_b = 16'h0824; req0_func = 4'b0010;
    req_valid = 2'b01;
    @(negedge clk);
    chk("lat_req_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = 2'b00;
    @(negedge clk);
    chk("lat_issue_busy", 32'(busy), 32'd1);
    chk("lat_issue_op_a", 32'(alu_op_a), 32'h0001);
    chk("lat_issue_func", 32'(alu_func), 32'h2);
    chk("lat_issue_noresp", 32'(rsp_valid), 32'd0);
    tick();
    @(negedge clk);
    chk("lat_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("lat_rsp_data", 32'(rsp_data), 32'h0825);
    chk("lat_rsp_err", 32'(rsp_err), 32'd0);
    tick();
    @(negedge clk);
    chk("lat_done_valid", 32'(rsp_valid), 32'd0);
    chk("lat_done_busy", 32'(busy), 32'd0);

    // Unsupported function code.
    do_txn(1'b1, 16'h0005, 16'h0003, 4'b0001, d, e);
    chk("bad_func_data", 32'(d), 32'h0);
    chk("bad_func_err", 32'(e), 32'd1);

    // Literal pins for or / xor.
    do_txn(1'b0, 16'h00F0, 16'h0F0F, 4'b1000, d, e);
    chk("or_data", 32'(d), 32'h0FFF);
    do_txn(1'b1, 16'hFFFF, 16'h0F0F, 4'b1010, d, e);
    chk("xor_data", 32'(d), 32'hF0F0);
    wait_idle();

    // Response withheld 5 cycles while requester 1 waits.
    rsp_ready = 2'b00;
    tick();
    req0_a = 16'h00F0; req0_b = 16'h000F; req0_func = 4'b0010;
    req_valid = 2'b01;
    @(negedge clk);
    chk("hold_req_ready0", 32'(req_ready), 32'h1);
    tick();
    req1_a = 16'hF0F0; req1_b = 16'h0FF0; req1_func = 4'b0110;
    req_valid = 2'b10;
    wait_rsp(2'b01);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("hold_rsp_data", 32'(rsp_data), 32'h00FF);
      chk("hold_busy", 32'(busy), 32'd1);
      chk("hold_req_ready", 32'(req_ready), 32'h0);
      tick();
      if (i == 2) rsp_ready = 2'b10;
    end
    rsp_ready = 2'b01;
    @(negedge clk);
    chk("hold_last_valid", 32'(rsp_valid), 32'h1);
    chk("hold_last_req_ready", 32'(req_ready), 32'h0);
    tick();
    rsp_ready = 2'b11;
    @(negedge clk);
    chk("hold_req1_grant", 32'(req_ready), 32'h2);
    tick();
    req_valid = 2'b00;
    wait_rsp(2'b10);
    chk("hold_req1_data", 32'(rsp_data), 32'h00F0);
    chk("hold_req1_err", 32'(rsp_err), 32'd0);
    wait_idle();

    // Reset during ISSUE drops the transaction.
    tick();
    req0_a = 16'h1111; req0_b = 16'h2222; req0_func = 4'b0010;
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    chk("rst_issue_pre_op_a", 32'(alu_op_a), 32'h1111);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_busy", 32'(busy), 32'd0);
    chk("rst_async_op_a", 32'(alu_op_a), 32'h0);
    chk("rst_async_op_b", 32'(alu_op_b), 32'h0);
    chk("rst_async_func", 32'(alu_func), 32'h0);
    chk("rst_async_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_async_rsp_data", 32'(rsp_data), 32'h0);
    chk("rst_async_rsp_err", 32'(rsp_err), 32'h0);
    chk("rst_async_req_ready", 32'(req_ready), 32'h0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_no_rsp", 32'(rsp_valid), 32'h0);
    end

    // Sweep all supported codes on both requesters.
    for (int idx = 0; idx < 2; idx++) begin
      for (int k = 0; k < 5; k++) begin
        a_v = 16'hA5C3 + 16'(k * 257 + idx * 4099);
        b_v = 16'h3C5A - 16'(k * 17);
        do_txn(idx[0], a_v, b_v, codes[k], d, e);
        chk("sweep_data", 32'(d), 32'(ref_result(a_v, b_v, codes[k])));
        chk("sweep_err", 32'(e), 32'd0);
      end
    end
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
